rf_port_ctrl: RTL and testbench

- Controller for one 512x36 simple-dual-port register-file BRAM (write port A, read port B, one clock).
- Shares the single write port between three sources, highest priority first: power-up/scrub clear, pipeline writeback, host/debug loader.
- Owns the read port and forwards in-flight writes, so a read returns the newest data at a fixed latency of 1.
- One instance sits beside each register-file bank, between the pipeline and the BRAM wrapper.

---
 rtl/rf_port_ctrl_pkg.sv | 26 ++
 rtl/rf_port_ctrl_if.sv | 49 ++++
 rtl/rf_fwd_unit.sv | 73 +++++++
 rtl/rf_port_ctrl.sv | 158 +++++++++++++++
 tb/tb_rf_port_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_port_ctrl_pkg.sv
// Shared types and constants for the register-file port controller.
package rf_port_ctrl_pkg;

  localparam int unsigned RF_AW = 9;
  localparam int unsigned RF_DW = 36;

  // Controller mode: clearing every entry, or serving pipeline/host traffic.
  typedef enum logic {
    StInit,
    StRun
  } rf_state_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    SrcNone,
    SrcInit,
    SrcPipe,
    SrcHost
  } rf_src_t;

  // True when a source actually drives a write.
  function automatic logic src_is_write(rf_src_t src);
    return src != SrcNone;
  endfunction

endpackage

// File: rtl/rf_port_ctrl_if.sv
// Pipeline, host and BRAM-side signals of one register-file bank controller.
interface rf_port_ctrl_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 36
) ();

  // Clear control
  logic          init_start;
  logic          init_busy;
  // Pipeline writeback
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata;
  // Host/debug loader
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  // Read port
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  // BRAM side
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_wd;
  logic          ram_ren;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_rd;

  // Controller view.
  modport slave (
    input  init_start, pipe_we, pipe_addr, pipe_wdata,
    input  host_req, host_addr, host_wdata,
    input  rd_en, rd_addr, ram_rd,
    output init_busy, host_ack, rd_data,
    output ram_we, ram_wa, ram_wd, ram_ren, ram_ra
  );

  // Environment view: pipeline, host and BRAM wrapper.
  modport master (
    output init_start, pipe_we, pipe_addr, pipe_wdata,
    output host_req, host_addr, host_wdata,
    output rd_en, rd_addr, ram_rd,
    input  init_busy, host_ack, rd_data,
    input  ram_we, ram_wa, ram_wd, ram_ren, ram_ra
  );

endinterface

// File: rtl/rf_fwd_unit.sv
// Read-side forwarding: compares the read address against the newest write
// (this cycle's winner) and the write still sitting on the BRAM port, so a
// read always sees the latest data one cycle later.
module rf_fwd_unit #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 36
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  // Winner chosen this cycle (not yet registered)
  input  logic          win_valid_i,
  input  logic [AW-1:0] win_addr_i,
  input  logic [DW-1:0] win_data_i,
  // Write on the BRAM port, commits at the coming edge
  input  logic          wr_valid_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [DW-1:0] ram_rd_i,
  output logic [DW-1:0] rd_data_o
);

  logic          hit_new, hit_old;
  logic          byp_q, byp_d;
  logic [DW-1:0] cap_q, cap_d;
  logic          rd_vld_q;
  logic [DW-1:0] hold_q;

  assign hit_new = win_valid_i && (win_addr_i == rd_addr_i);
  assign hit_old = wr_valid_i && (wr_addr_i == rd_addr_i);

  // Capture bypass data when a read is sampled; newest write wins.
  always_comb begin
    byp_d = byp_q;
    cap_d = cap_q;
    if (rd_en_i) begin
      byp_d = hit_new || hit_old;
      if (hit_new) begin
        cap_d = win_data_i;
      end else if (hit_old) begin
        cap_d = wr_data_i;
      end
    end
  end

  // Bypass flag, captured data, read-valid and held output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byp_q    <= 1'b0;
      cap_q    <= '0;
      rd_vld_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      byp_q    <= byp_d;
      cap_q    <= cap_d;
      rd_vld_q <= rd_en_i;
      hold_q   <= rd_data_o;
    end
  end

  // Without a read last cycle the output keeps its previous value.
  always_comb begin
    if (!rd_vld_q) begin
      rd_data_o = hold_q;
    end else if (byp_q) begin
      rd_data_o = cap_q;
    end else begin
      rd_data_o = ram_rd_i;
    end
  end

endmodule

// File: rtl/rf_port_ctrl.sv
// Register-file bank controller: arbitrates the single BRAM write port between
// clear, pipeline writeback and host loader, and serves forwarded reads.
module rf_port_ctrl
  import rf_port_ctrl_pkg::*;
#(
  parameter int unsigned   AW       = RF_AW,
  parameter int unsigned   DW       = RF_DW,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic           clk,
  input logic           rstn,
  rf_port_ctrl_if.slave bus
);

  localparam logic [AW-1:0] CntLast = '1;

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  rf_src_t       win_src;
  logic          win_valid;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          init_busy;
  logic          host_ack;

  logic          ram_we_q;
  logic [AW-1:0] ram_wa_q;
  logic [DW-1:0] ram_wd_q;

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every address once, then serve traffic until a restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CntLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.init_start) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs per state: write-port owner, busy flag and host acknowledge.
  always_comb begin
    win_src   = SrcNone;
    init_busy = 1'b0;
    host_ack  = 1'b0;
    unique case (state_q)
      StInit: begin
        init_busy = 1'b1;
        win_src   = SrcInit;
      end
      StRun: begin
        // Writeback is never stalled, so the host may starve behind it.
        if (bus.pipe_we) begin
          win_src = SrcPipe;
        end else if (bus.host_req) begin
          win_src  = SrcHost;
          host_ack = 1'b1;
        end
      end
      default: begin
        init_busy = 1'b1;
      end
    endcase
  end

  // Route the winning source onto the write address/data.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    unique case (win_src)
      SrcInit: begin
        win_addr = cnt_q;
        win_data = INIT_VAL;
      end
      SrcPipe: begin
        win_addr = bus.pipe_addr;
        win_data = bus.pipe_wdata;
      end
      SrcHost: begin
        win_addr = bus.host_addr;
        win_data = bus.host_wdata;
      end
      default: begin
        win_addr = '0;
        win_data = '0;
      end
    endcase
  end

  assign win_valid = src_is_write(win_src);

  // Register the winner onto the BRAM write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_we_q <= 1'b0;
      ram_wa_q <= '0;
      ram_wd_q <= '0;
    end else begin
      ram_we_q <= win_valid;
      if (win_valid) begin
        ram_wa_q <= win_addr;
        ram_wd_q <= win_data;
      end
    end
  end

  rf_fwd_unit #(
    .AW (AW),
    .DW (DW)
  ) u_fwd (
    .clk         (clk),
    .rstn        (rstn),
    .rd_en_i     (bus.rd_en),
    .rd_addr_i   (bus.rd_addr),
    .win_valid_i (win_valid),
    .win_addr_i  (win_addr),
    .win_data_i  (win_data),
    .wr_valid_i  (ram_we_q),
    .wr_addr_i   (ram_wa_q),
    .wr_data_i   (ram_wd_q),
    .ram_rd_i    (bus.ram_rd),
    .rd_data_o   (bus.rd_data)
  );

  assign bus.init_busy = init_busy;
  assign bus.host_ack  = host_ack;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wa    = ram_wa_q;
  assign bus.ram_wd    = ram_wd_q;
  assign bus.ram_ren   = bus.rd_en;
  assign bus.ram_ra    = bus.rd_addr;

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Bench for rf_port_ctrl: BRAM model, architectural reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_rf_port_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 36;
  localparam int unsigned DEPTH = 512;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  rf_port_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  rf_port_ctrl #(
    .AW       (AW),
    .DW       (DW),
    .INIT_VAL ('0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Simple-dual-port BRAM, read-first on collisions, DO_REG=0.
  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) bram[bus.ram_wa] <= bus.ram_wd;
    if (bus.ram_ren) bus.ram_rd <= bram[bus.ram_ra];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: logical register file where a write is visible to a read
  // sampled in the same cycle; the clear is a 512-cycle sweep.
  bit            m_busy;
  int            m_cnt;
  bit            m_ack;
  bit            e_we;
  logic [AW-1:0] e_wa;
  logic [DW-1:0] e_wd;
  logic [DW-1:0] e_rd;
  logic [DW-1:0] ref_mem [DEPTH];

  always @(negedge clk) begin
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!rstn) begin
      m_busy = 1'b1; m_cnt = 0; m_ack = 1'b0;
      e_we = 1'b0; e_wa = '0; e_wd = '0; e_rd = '0;
      check("rst_busy", 64'(bus.init_busy), 64'd1);
      check("rst_ram_we", 64'(bus.ram_we), 64'd0);
      check("rst_ram_wa", 64'(bus.ram_wa), 64'd0);
      check("rst_ram_wd", 64'(bus.ram_wd), 64'd0);
      check("rst_host_ack", 64'(bus.host_ack), 64'd0);
      check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    end else begin
      m_ack = !m_busy && bus.host_req && !bus.pipe_we;
      check("init_busy", 64'(bus.init_busy), 64'(m_busy));
      check("host_ack", 64'(bus.host_ack), 64'(m_ack));
      check("ram_we", 64'(bus.ram_we), 64'(e_we));
      if (e_we) begin
        check("ram_wa", 64'(bus.ram_wa), 64'(e_wa));
        check("ram_wd", 64'(bus.ram_wd), 64'(e_wd));
      end
      check("rd_data", 64'(bus.rd_data), 64'(e_rd));
      check("ram_ren", 64'(bus.ram_ren), 64'(bus.rd_en));
      if (bus.rd_en) check("ram_ra", 64'(bus.ram_ra), 64'(bus.rd_addr));
      // Winner of this cycle by priority.
      w = 1'b1; a = '0; d = '0;
      if (m_busy) begin
        a = AW'(m_cnt);
      end else if (bus.pipe_we) begin
        a = bus.pipe_addr; d = bus.pipe_wdata;
      end else if (bus.host_req) begin
        a = bus.host_addr; d = bus.host_wdata;
      end else begin
        w = 1'b0;
      end
      if (bus.rd_en) e_rd = (w && a == bus.rd_addr) ? d : ref_mem[bus.rd_addr];
      if (w) ref_mem[a] = d;
      e_we = w;
      if (w) begin e_wa = a; e_wd = d; end
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == int'(DEPTH)) begin m_busy = 1'b0; m_cnt = 0; end
      end else if (bus.init_start) begin
        m_busy = 1'b1; m_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.init_start = 1'b0; bus.pipe_we = 1'b0; bus.host_req = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic pipe_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.pipe_we = 1'b1; bus.pipe_addr = a; bus.pipe_wdata = d;
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    summary();
    $finish;
  end

  initial begin
    int n;
    for (int i = 0; i < int'(DEPTH); i++) bram[i] = {4'($urandom_range(0, 15)), 32'($urandom())};
    idle_inputs();
    bus.pipe_addr = '0; bus.pipe_wdata = '0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.rd_addr = '0;
    #1 rstn = 1'b0;
    repeat (3) step();
    check("lit_rst_busy", 64'(bus.init_busy), 64'd1);
    check("lit_rst_we", 64'(bus.ram_we), 64'd0);
    rstn = 1'b1;

    // Clear sweep after reset release.
    for (int i = 0; i < int'(DEPTH); i++) begin
      step();
      check("lit_clr_we", 64'(bus.ram_we), 64'd1);
      check("lit_clr_wa", 64'(bus.ram_wa), 64'(i));
      check("lit_clr_wd", 64'(bus.ram_wd), 64'd0);
      check("lit_clr_busy", 64'(bus.init_busy), (i < int'(DEPTH) - 1) ? 64'd1 : 64'd0);
    end
    bus.rd_en = 1'b1; bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
    step();
    bus.rd_en = 1'b0;
    check("lit_rd_after_clr", 64'(bus.rd_data), 64'd0);

    // Pipe beats host; host acked the following cycle.
    pipe_wr(9'd5, 36'h1234);
    bus.host_req = 1'b1; bus.host_addr = 9'd7; bus.host_wdata = 36'hABCD;
    #1 check("lit_ack_blocked", 64'(bus.host_ack), 64'd0);
    step();
    check("lit_pipe_wa", 64'(bus.ram_wa), 64'd5);
    check("lit_pipe_wd", 64'(bus.ram_wd), 64'h1234);
    bus.pipe_we = 1'b0;
    #1 check("lit_ack_pulse", 64'(bus.host_ack), 64'd1);
    step();
    bus.host_req = 1'b0;
    check("lit_host_wa", 64'(bus.ram_wa), 64'd7);
    check("lit_host_wd", 64'(bus.ram_wd), 64'hABCD);
    bus.rd_en = 1'b1; bus.rd_addr = 9'd5;
    step();
    check("lit_rd5", 64'(bus.rd_data), 64'h1234);
    bus.rd_addr = 9'd7;
    step();
    bus.rd_en = 1'b0;
    check("lit_rd7", 64'(bus.rd_data), 64'hABCD);

    // Forwarding from the current winner, from ram_*, and from the BRAM.
    pipe_wr(9'd3, 36'hF00D); bus.rd_en = 1'b1; bus.rd_addr = 9'd3;
    step();
    bus.pipe_we = 1'b0; bus.rd_en = 1'b0;
    check("lit_fwd_same", 64'(bus.rd_data), 64'hF00D);
    pipe_wr(9'd3, 36'hBEEF);
    step();
    bus.pipe_we = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = 9'd3;
    step();
    bus.rd_en = 1'b0;
    check("lit_fwd_next", 64'(bus.rd_data), 64'hBEEF);
    pipe_wr(9'd3, 36'hC0DE);
    step();
    bus.pipe_we = 1'b0;
    step();
    step();
    bus.rd_en = 1'b1; bus.rd_addr = 9'd3;
    step();
    bus.rd_en = 1'b0;
    check("lit_fwd_bram", 64'(bus.rd_data), 64'hC0DE);

    // Back-to-back writes: newest wins.
    pipe_wr(9'd9, 36'h1);
    step();
    pipe_wr(9'd9, 36'h2); bus.rd_en = 1'b1; bus.rd_addr = 9'd9;
    step();
    bus.pipe_we = 1'b0; bus.rd_en = 1'b0;
    check("lit_b2b", 64'(bus.rd_data), 64'h2);

    // Restart clear from RUN.
    for (int i = 0; i < 4; i++) begin
      pipe_wr(AW'(i), 36'h100 + 36'(i));
      step();
    end
    bus.pipe_we = 1'b0; bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    n = 0;
    while (bus.init_busy && n < 600) begin n++; step(); end
    check("lit_init_len", 64'(n), 64'd512);
    for (int i = 0; i < 4; i++) begin
      bus.rd_en = 1'b1; bus.rd_addr = AW'(i);
      step();
      check("lit_rd_cleared", 64'(bus.rd_data), 64'd0);
    end

    // Reset in the middle of a clear with a host request pending.
    pipe_wr(9'd50, 36'h55); bus.rd_en = 1'b0;
    step();
    bus.pipe_we = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = 9'd50;
    step();
    bus.rd_en = 1'b0;
    check("lit_rd50", 64'(bus.rd_data), 64'h55);
    bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    bus.host_req = 1'b1; bus.host_addr = 9'd20; bus.host_wdata = 36'h77;
    repeat (200) begin
      step();
      check("lit_ack_in_init", 64'(bus.host_ack), 64'd0);
    end
    check("lit_cnt200", 64'(bus.ram_wa), 64'd199);
    rstn = 1'b0;
    #1;
    check("lit_mid_rst_busy", 64'(bus.init_busy), 64'd1);
    check("lit_mid_rst_we", 64'(bus.ram_we), 64'd0);
    check("lit_mid_rst_wa", 64'(bus.ram_wa), 64'd0);
    check("lit_mid_rst_rd", 64'(bus.rd_data), 64'd0);
    step();
    rstn = 1'b1;
    step();
    check("lit_restart_wa", 64'(bus.ram_wa), 64'd0);
    n = 0;
    while (bus.init_busy && n < 600) begin
      check("lit_ack_wait", 64'(bus.host_ack), 64'd0);
      n++;
      step();
    end
    check("lit_restart_len", 64'(n), 64'd511);
    check("lit_ack_after", 64'(bus.host_ack), 64'd1);
    step();
    bus.host_req = 1'b0;
    check("lit_host20_wa", 64'(bus.ram_wa), 64'd20);
    check("lit_host20_wd", 64'(bus.ram_wd), 64'h77);

    // Random traffic on a small address window to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      logic busy;
      busy = bus.init_busy;
      bus.pipe_we = !busy && ($urandom_range(0, 1) == 1);
      bus.pipe_addr = AW'($urandom_range(0, 15));
      bus.pipe_wdata = {4'($urandom_range(0, 15)), 32'($urandom())};
      if (!bus.host_req || m_ack) begin
        bus.host_req = ($urandom_range(0, 2) == 0);
        bus.host_addr = AW'($urandom_range(0, 15));
        bus.host_wdata = {4'($urandom_range(0, 15)), 32'($urandom())};
      end
      bus.rd_en = !busy && ($urandom_range(0, 1) == 1);
      bus.rd_addr = AW'($urandom_range(0, 15));
      bus.init_start = !busy && ($urandom_range(0, 999) == 0);
      step();
    end
    idle_inputs();
    repeat (3) step();
    summary();
    $finish;
  end

endmodule
